// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the binarised fully-connected layer:
//   - bnn_state_e : controller state encoding (WAIT=0 .. SND=4)
//   - clog2       : counter/index width helper, never returns less than 1
// -----------------------------------------------------------------------------
package bnn_pkg;

    typedef enum logic [2:0] {
        StWait    = 3'd0,
        StRcv     = 3'd1,
        StCalc    = 3'd2,
        StSndWait = 3'd3,
        StSnd     = 3'd4
    } bnn_state_e;

    // Width needed to index 'value' entries; clamped to 1 so that a
    // single-entry counter still has a real bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bnn_weight_rom.sv
// -----------------------------------------------------------------------------
// bnn_weight_rom
// Read-only weight and bias store, one row per neuron, read combinationally.
// Contents come from the packed W_INIT / B_INIT parameters (row j in slice j,
// LSB-first). W_FILE / B_FILE are kept as parameters of the interface.
// Ports:
//   i_idx  : neuron index
//   o_w    : N_IN-bit weight row of neuron i_idx
//   o_bias : signed OUT_W-bit bias of neuron i_idx
// -----------------------------------------------------------------------------
module bnn_weight_rom
    import bnn_pkg::*;
#(
    parameter int unsigned            N_IN   = 32,
    parameter int unsigned            N_OUT  = 10,
    parameter int unsigned            OUT_W  = 8,
    parameter int unsigned            IDX_W  = clog2(N_OUT),
    parameter                         W_FILE = "w.txt",
    parameter                         B_FILE = "b.txt",
    parameter logic [N_OUT*N_IN-1:0]  W_INIT = '1,
    parameter logic [N_OUT*OUT_W-1:0] B_INIT = '0
) (
    input  logic        [IDX_W-1:0] i_idx,
    output logic        [N_IN-1:0]  o_w,
    output logic signed [OUT_W-1:0] o_bias
);

    assign o_w    = W_INIT[i_idx*N_IN +: N_IN];
    assign o_bias = B_INIT[i_idx*OUT_W +: OUT_W];

endmodule

// File: rtl/bnn_fc_layer.sv
// -----------------------------------------------------------------------------
// bnn_fc_layer
// Binarised fully-connected layer. A frame is received with a req/ack
// handshake, then each neuron's XNOR-popcount is accumulated LANES bits per
// cycle, bias added, and the result (saturated count or binarised bit) is
// collected in a shadow register that is published atomically at the end.
// Ports:
//   clk      : clock, rising edge
//   xrst     : asynchronous active-low reset
//   inputs   : N_IN-bit activation vector, captured in RCV
//   rcv_ack  : upstream data valid (only honoured in WAIT)
//   rcv_req  : ready for a new frame (WAIT)
//   snd_req  : downstream request for results
//   snd_ack  : results being presented (SND)
//   outputs  : per-neuron results, neuron j in slice j, LSB-first
//   busy     : frame in progress (RCV, CALC)
// -----------------------------------------------------------------------------
module bnn_fc_layer
    import bnn_pkg::*;
#(
    parameter int unsigned            N_IN     = 32,
    parameter int unsigned            N_OUT    = 10,
    parameter int unsigned            LANES    = 8,
    parameter int unsigned            OUT_MODE = 0,
    parameter int unsigned            OUT_W    = 8,
    parameter                         W_FILE   = "w.txt",
    parameter                         B_FILE   = "b.txt",
    parameter logic [N_OUT*N_IN-1:0]  W_INIT   = '1,
    parameter logic [N_OUT*OUT_W-1:0] B_INIT   = '0
) (
    input  logic                                            clk,
    input  logic                                            xrst,
    input  logic [N_IN-1:0]                                 inputs,
    input  logic                                            rcv_ack,
    output logic                                            rcv_req,
    input  logic                                            snd_req,
    output logic                                            snd_ack,
    output logic [N_OUT*((OUT_MODE != 0) ? 1 : OUT_W)-1:0]  outputs,
    output logic                                            busy
);

    localparam int unsigned NBITS   = (OUT_MODE != 0) ? 1 : OUT_W;
    localparam int unsigned RES_W   = N_OUT * NBITS;
    localparam int unsigned CHUNKS  = N_IN / LANES;
    localparam int unsigned CHUNK_W = clog2(CHUNKS);
    localparam int unsigned NEUR_W  = clog2(N_OUT);
    localparam int unsigned ACC_W   = clog2(N_IN + 1);
    localparam int unsigned PC_W    = clog2(LANES + 1);
    // Two guard bits: one for the sign, one so acc + bias cannot overflow.
    localparam int unsigned SUM_W   = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
    localparam logic [NEUR_W-1:0]  LAST_NEUR  = NEUR_W'(N_OUT - 1);

    bnn_state_e              r_state;
    logic [N_IN-1:0]         r_x;
    logic [ACC_W-1:0]        r_acc;
    logic [CHUNK_W-1:0]      r_chunk;
    logic [NEUR_W-1:0]       r_neur;
    logic [RES_W-1:0]        r_shadow;
    logic [RES_W-1:0]        r_out;
    logic                    r_rcv_req;
    logic                    r_snd_ack;
    logic                    r_busy;

    logic [N_IN-1:0]         w_w;
    logic signed [OUT_W-1:0] w_bias;
    logic [LANES-1:0]        w_match;
    logic [PC_W-1:0]         w_pc;
    logic signed [SUM_W-1:0] w_bias_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic [NBITS-1:0]        w_res;
    logic [RES_W-1:0]        w_shadow_nxt;
    logic                    w_last_chunk;
    logic                    w_last_neur;

    bnn_weight_rom #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .OUT_W  (OUT_W),
        .IDX_W  (NEUR_W),
        .W_FILE (W_FILE),
        .B_FILE (B_FILE),
        .W_INIT (W_INIT),
        .B_INIT (B_INIT)
    ) u_rom (
        .i_idx  (r_neur),
        .o_w    (w_w),
        .o_bias (w_bias)
    );

    assign w_last_chunk = (r_chunk == LAST_CHUNK);
    assign w_last_neur  = (r_neur == LAST_NEUR);

    // XNOR marks agreeing bits of the current chunk.
    assign w_match = ~(r_x[r_chunk*LANES +: LANES] ^ w_w[r_chunk*LANES +: LANES]);

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pc = w_pc + PC_W'(w_match[i]);
        end
    end

    // Full-precision neuron total, only meaningful on the last chunk.
    assign w_bias_ext = {{(SUM_W - OUT_W){w_bias[OUT_W-1]}}, w_bias};
    assign w_sum      = $signed(SUM_W'(r_acc) + SUM_W'(w_pc)) + w_bias_ext;

    if (OUT_MODE != 0) begin : g_bin
        logic signed [SUM_W:0] w_twice;
        assign w_twice = {w_sum, 1'b0};
        assign w_res   = (w_twice >= $signed((SUM_W + 1)'(N_IN)));
    end else begin : g_cnt
        localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'd1 << (OUT_W - 1)) - 64'd1);
        localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
        always_comb begin
            if (w_sum > SAT_MAX) begin
                w_res = SAT_MAX[OUT_W-1:0];
            end else if (w_sum < SAT_MIN) begin
                w_res = SAT_MIN[OUT_W-1:0];
            end else begin
                w_res = w_sum[OUT_W-1:0];
            end
        end
    end

    // Shadow with the current neuron's slice merged in, so the last neuron
    // lands in the published outputs on the same edge.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[r_neur*NBITS +: NBITS] = w_res;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state   <= StWait;
            r_x       <= '0;
            r_acc     <= '0;
            r_chunk   <= '0;
            r_neur    <= '0;
            r_shadow  <= '0;
            r_out     <= '0;
            r_rcv_req <= 1'b1;
            r_snd_ack <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                StWait: begin
                    if (rcv_ack) begin
                        r_state   <= StRcv;
                        r_rcv_req <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                StRcv: begin
                    r_x     <= inputs;
                    r_state <= StCalc;
                end
                StCalc: begin
                    if (w_last_chunk) begin
                        r_chunk  <= '0;
                        r_acc    <= '0;
                        r_shadow <= w_shadow_nxt;
                        if (w_last_neur) begin
                            r_neur  <= '0;
                            r_out   <= w_shadow_nxt;
                            r_busy  <= 1'b0;
                            r_state <= StSndWait;
                        end else begin
                            r_neur <= r_neur + NEUR_W'(1);
                        end
                    end else begin
                        r_chunk <= r_chunk + CHUNK_W'(1);
                        r_acc   <= r_acc + ACC_W'(w_pc);
                    end
                end
                StSndWait: begin
                    if (snd_req) begin
                        r_state   <= StSnd;
                        r_snd_ack <= 1'b1;
                    end
                end
                StSnd: begin
                    if (!snd_req) begin
                        r_state   <= StWait;
                        r_snd_ack <= 1'b0;
                        r_rcv_req <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StWait;
                end
            endcase
        end
    end

    assign rcv_req = r_rcv_req;
    assign snd_ack = r_snd_ack;
    assign busy    = r_busy;
    assign outputs = r_out;

endmodule
